// File: rtl/pipe_arb_pkg.sv
// pipe_arb_pkg: shared types, port ids and counter-width helper for the pipeline memory arbiter
package pipe_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pipe_arb_perf.sv
// pipe_arb_perf: saturating stall-cycle counters for the fetch and data ports
// Ports: clk, rst_n (async active-low), stall_if/stall_mem in, perf_if_wait/perf_d_wait out.
module pipe_arb_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        stall_mem,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_d_wait
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
    end else begin
      if (stall_if && !(&perf_if_wait)) perf_if_wait <= perf_if_wait + 32'd1;
      if (stall_mem && !(&perf_d_wait)) perf_d_wait <= perf_d_wait + 32'd1;
    end
endmodule

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one fixed-latency single-port memory between the IF and MEM stages
// Ports: clk, rst_n (async active-low); fetch port if_req/if_addr/if_kill -> if_ack/if_rdata;
//   data port d_req/d_we/d_be/d_addr/d_wdata -> d_ack/d_rdata; memory side m_en/m_we/m_be/
//   m_addr/m_wdata <- m_rdata; stall_if/stall_mem to hazard logic.
// Macro PIPE_ARB_PERF_EN adds perf_if_wait/perf_d_wait stall-cycle counters.
module pipe_mem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                stall_if,
  output logic                stall_mem
`ifdef PIPE_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_wait,
  output logic [31:0]         perf_d_wait
`endif
);
  localparam int CW = clog2(MEM_LAT) < 1 ? 1 : clog2(MEM_LAT);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic kill_pend, d_elig, i_elig, grant, win, done, i_fin;
  // A request whose ack is high this cycle is the one just served, still held by the stage.
  always_comb begin
    d_elig  = d_req & ~d_ack;
    i_elig  = if_req & ~if_ack;
    grant   = (state == IDLE) & (d_elig | i_elig);
    win     = d_elig ? PORT_D : PORT_I;
    done    = (state != IDLE) & (cnt == LAST);
    i_fin   = done & (state == BUSY_I) & ~(kill_pend | if_kill);
    state_n = grant ? (win == PORT_D ? BUSY_D : BUSY_I) : done ? IDLE : state;
  end
  assign m_en      = state != IDLE;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      kill_pend <= 1'b0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      m_we      <= 1'b0;
      m_be      <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      cnt       <= (state == IDLE || done) ? '0 : cnt + 1'b1;
      kill_pend <= (state == BUSY_I) & ~done & (kill_pend | if_kill);
      if_ack    <= i_fin;
      d_ack     <= done & (state == BUSY_D);
      if (i_fin) if_rdata <= m_rdata;
      if (done && state == BUSY_D && !m_we) d_rdata <= m_rdata;
      if (grant) begin
        m_we    <= (win == PORT_D) & d_we;
        m_be    <= win == PORT_D ? d_be : '1;
        m_addr  <= win == PORT_D ? d_addr : if_addr;
        m_wdata <= win == PORT_D ? d_wdata : '0;
      end
    end
`ifdef PIPE_ARB_PERF_EN
  pipe_arb_perf u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .perf_if_wait (perf_if_wait),
    .perf_d_wait  (perf_d_wait)
  );
`endif
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed self-checking bench for pipe_mem_arbiter with MEM_LAT=2
module tb_pipe_mem_arbiter;
  logic        clk, rst_n;
  logic        if_req, if_kill, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, m_be;
  logic        m_en, m_we, stall_if, stall_mem;
  logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef PIPE_ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_d_wait;
`endif
  int total = 0;
  int bad = 0;
  // Memory model: one fixed instruction at 0x10, otherwise a tag derived from the address.
  assign m_rdata = (m_addr == 32'h10) ? 32'h00A00093 : {16'hD0D0, m_addr[15:0]};
  pipe_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_kill   (if_kill),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .m_en      (m_en),
    .m_we      (m_we),
    .m_be      (m_be),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
`ifdef PIPE_ARB_PERF_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_d_wait  (perf_d_wait)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h14; if_kill = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200; d_wdata = '0;
    tick(); tick();
    chk("rst_m_en", 32'(m_en), 0);
    chk("rst_if_ack", 32'(if_ack), 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_be", 32'(m_be), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    // Release mid-cycle T with both requests pending: data wins.
    rst_n = 1'b1;
    tick();
    chk("both_t1_m_en", 32'(m_en), 1);
    chk("both_t1_m_addr", m_addr, 32'h200);
    chk("both_t1_m_we", 32'(m_we), 0);
    chk("both_t1_stall_if", 32'(stall_if), 1);
    tick();
    chk("both_t2_m_en", 32'(m_en), 1);
    chk("both_t2_d_ack", 32'(d_ack), 0);
    tick();
    chk("both_t3_d_ack", 32'(d_ack), 1);
    chk("both_t3_d_rdata", d_rdata, 32'hD0D00200);
    chk("both_t3_m_en", 32'(m_en), 0);
    chk("both_t3_stall_mem", 32'(stall_mem), 0);
    chk("both_t3_stall_if", 32'(stall_if), 1);
    d_req = 1'b0;
    tick();
    chk("both_t4_d_ack", 32'(d_ack), 0);
    chk("both_t4_m_addr", m_addr, 32'h14);
    chk("both_t4_m_be", 32'(m_be), 32'hF);
    chk("both_t4_stall_if", 32'(stall_if), 1);
    tick();
    chk("both_t5_if_ack", 32'(if_ack), 0);
    tick();
    chk("both_t6_if_ack", 32'(if_ack), 1);
    chk("both_t6_if_rdata", if_rdata, 32'hD0D00014);
    chk("both_t6_stall_if", 32'(stall_if), 0);
`ifdef PIPE_ARB_PERF_EN
    chk("perf_if_wait", perf_if_wait, 6);
    chk("perf_d_wait", perf_d_wait, 3);
`endif
    if_req = 1'b0;
    tick();
    chk("idle_if_ack", 32'(if_ack), 0);
    chk("idle_m_en", 32'(m_en), 0);
    // Fetch only at 0x10.
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    chk("f_c1_m_en", 32'(m_en), 1);
    chk("f_c1_m_addr", m_addr, 32'h10);
    tick();
    chk("f_c2_m_en", 32'(m_en), 1);
    chk("f_c2_if_ack", 32'(if_ack), 0);
    tick();
    chk("f_c3_if_ack", 32'(if_ack), 1);
    chk("f_c3_if_rdata", if_rdata, 32'h00A00093);
    chk("f_c3_m_en", 32'(m_en), 0);
    if_req = 1'b0;
    tick();
    chk("f_c4_if_ack", 32'(if_ack), 0);
    // Store 0x204.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h204; d_wdata = 32'hBEEF;
    tick();
    chk("st_c1_m_we", 32'(m_we), 1);
    chk("st_c1_m_be", 32'(m_be), 32'h3);
    chk("st_c1_m_addr", m_addr, 32'h204);
    chk("st_c1_m_wdata", m_wdata, 32'hBEEF);
    tick();
    chk("st_c2_m_en", 32'(m_en), 1);
    chk("st_c2_m_we", 32'(m_we), 1);
    tick();
    chk("st_c3_d_ack", 32'(d_ack), 1);
    chk("st_c3_d_rdata", d_rdata, 32'hD0D00200);
    d_req = 1'b0; d_we = 1'b0; d_be = 4'hF;
    tick();
    chk("st_c4_d_ack", 32'(d_ack), 0);
    // Fetch 0x18 killed in its final cycle while a load waits.
    if_req = 1'b1; if_addr = 32'h18;
    tick();
    chk("k_c1_m_addr", m_addr, 32'h18);
    tick();
    if_kill = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h208;
    tick();
    if_kill = 1'b0;
    chk("k_if_ack", 32'(if_ack), 0);
    chk("k_if_rdata", if_rdata, 32'h00A00093);
    chk("k_m_en", 32'(m_en), 0);
    tick();
    chk("k_d_grant_m_en", 32'(m_en), 1);
    chk("k_d_grant_m_addr", m_addr, 32'h208);
    chk("k_if_ack2", 32'(if_ack), 0);
    tick(); tick();
    chk("k_d_ack", 32'(d_ack), 1);
    chk("k_d_rdata", d_rdata, 32'hD0D00208);
    d_req = 1'b0;
    tick();
    chk("k_refetch_m_addr", m_addr, 32'h40);
    tick(); tick();
    chk("k_refetch_if_ack", 32'(if_ack), 1);
    chk("k_refetch_if_rdata", if_rdata, 32'hD0D00040);
    if_req = 1'b0;
    tick();
    // Async reset in the middle of a load.
    d_req = 1'b1; d_addr = 32'h20C;
    tick();
    chk("ar_m_en_before", 32'(m_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_m_en_now", 32'(m_en), 0);
    chk("ar_m_addr_now", m_addr, 0);
`ifdef PIPE_ARB_PERF_EN
    chk("ar_perf_if", perf_if_wait, 0);
    chk("ar_perf_d", perf_d_wait, 0);
`endif
    tick();
    chk("ar_d_ack_rst", 32'(d_ack), 0);
    chk("ar_d_rdata_rst", d_rdata, 0);
    rst_n = 1'b1; d_req = 1'b0;
    tick();
    chk("ar_d_ack_after", 32'(d_ack), 0);
    chk("ar_m_en_after", 32'(m_en), 0);
    tick();
    chk("ar_d_ack_after2", 32'(d_ack), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
